// File: rtl/router_pkg.sv
// Types and widths shared by the router's input port, arbiter and port_out.
package router_pkg;

   localparam int ADDR_W    = 4;
   localparam int PAYLOAD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      PAY  = 2'd2,
      GAP  = 2'd3
   } port_out_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]    addr;
      logic [PAYLOAD_W-1:0] payload;
   } packet_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pkt_hold_reg.sv
// Single-entry holding register: valid flag plus data, written on accept and
// cleared when the consumer takes the entry.
module pkt_hold_reg #(
   parameter int W = 36
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_wr,
   input  logic         i_clr,
   input  logic [W-1:0] i_wdata,
   output logic         o_full,
   output logic [W-1:0] o_rdata
);

   logic         r_full;
   logic [W-1:0] r_data;

   // The producer only writes while empty, so write and clear never coincide.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else if (i_wr) begin
         r_full <= 1'b1;
         r_data <= i_wdata;
      end else if (i_clr) begin
         r_full <= 1'b0;
      end
   end

   assign o_full  = r_full;
   assign o_rdata = r_data;

endmodule

// File: rtl/port_out.sv
// Router serial output port: takes one parallel packet and shifts it out
// LSB-first as an address phase then a payload phase, followed by idle gap cycles.
module port_out #(
   parameter int AW  = router_pkg::ADDR_W,
   parameter int PW  = router_pkg::PAYLOAD_W,
   parameter int GAP = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_vld,
   input  logic [AW-1:0] in_addr,
   input  logic [PW-1:0] in_payload,
   output logic          in_rdy,
   output logic          frame_n,
   output logic          valid_n,
   output logic          dout,
   output logic          busy,
   output logic          sent,
   output logic [1:0]    dbg_state
);

   import router_pkg::*;

   localparam int HW = AW + PW;
   localparam int CW = $clog2(router_pkg::max3(AW, PW, GAP) + 1);

   localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
   localparam logic [CW-1:0] PAY_LAST  = CW'(PW - 1);
   localparam logic [CW-1:0] PAY_PEN   = CW'(PW - 2);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

   logic            w_hold_full;
   logic [HW-1:0]   w_hold_data;
   logic            w_accept;
   logic            w_gap_last;
   logic            w_load;
   logic            w_next_idle;
   logic            w_hold_next;

   port_out_state_e r_state;
   logic [CW-1:0]   r_cnt;
   logic [AW-1:0]   r_addr_sh;
   logic [PW-1:0]   r_pay_sh;
   logic            r_frame_n;
   logic            r_valid_n;
   logic            r_dout;
   logic            r_sent;
   logic            r_busy;

   assign w_accept    = in_vld && !w_hold_full;
   assign w_gap_last  = (r_state == router_pkg::GAP) && (r_cnt == GAP_LAST);
   assign w_load      = w_hold_full && ((r_state == IDLE) || w_gap_last);
   assign w_next_idle = ((r_state == IDLE) || w_gap_last) && !w_hold_full;
   assign w_hold_next = w_accept || (w_hold_full && !w_load);

   pkt_hold_reg #(.W(HW)) u_hold (
      .i_clk   (clock),
      .i_rst   (reset),
      .i_wr    (w_accept),
      .i_clr   (w_load),
      .i_wdata ({in_addr, in_payload}),
      .o_full  (w_hold_full),
      .o_rdata (w_hold_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_addr_sh <= '0;
         r_pay_sh  <= '0;
         r_frame_n <= 1'b1;
         r_valid_n <= 1'b1;
         r_dout    <= 1'b0;
         r_sent    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_busy <= !w_next_idle || w_hold_next;
         case (r_state)
            IDLE: begin
            end
            ADDR: begin
               if (r_cnt == ADDR_LAST) begin
                  r_state   <= PAY;
                  r_cnt     <= '0;
                  r_valid_n <= 1'b0;
                  r_frame_n <= (PW == 1);
                  r_sent    <= (PW == 1);
                  r_dout    <= r_pay_sh[0];
                  r_pay_sh  <= r_pay_sh >> 1;
               end else begin
                  r_cnt     <= r_cnt + 1'b1;
                  r_dout    <= r_addr_sh[0];
                  r_addr_sh <= r_addr_sh >> 1;
               end
            end
            PAY: begin
               if (r_cnt == PAY_LAST) begin
                  r_state   <= router_pkg::GAP;
                  r_cnt     <= '0;
                  r_frame_n <= 1'b1;
                  r_valid_n <= 1'b1;
                  r_dout    <= 1'b0;
                  r_sent    <= 1'b0;
               end else begin
                  // Final payload bit doubles as the end-of-frame marker.
                  r_cnt     <= r_cnt + 1'b1;
                  r_dout    <= r_pay_sh[0];
                  r_pay_sh  <= r_pay_sh >> 1;
                  r_frame_n <= (r_cnt == PAY_PEN);
                  r_sent    <= (r_cnt == PAY_PEN);
               end
            end
            router_pkg::GAP: begin
               if (w_gap_last) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase

         // Loading overrides the state-local updates above; address bit 0 goes out now.
         if (w_load) begin
            r_state   <= ADDR;
            r_cnt     <= '0;
            r_addr_sh <= w_hold_data[HW-1:PW] >> 1;
            r_pay_sh  <= w_hold_data[PW-1:0];
            r_dout    <= w_hold_data[PW];
            r_frame_n <= 1'b0;
            r_valid_n <= 1'b1;
            r_sent    <= 1'b0;
         end
      end
   end

   assign in_rdy    = !w_hold_full;
   assign frame_n   = r_frame_n;
   assign valid_n   = r_valid_n;
   assign dout      = r_dout;
   assign sent      = r_sent;
   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule
